// File: rtl/eth_rx_frame_filter_pkg.sv
// Shared types and helpers for the Ethernet RX frame filter.
// The destination-address acceptance rule lives here so the TX path can reuse it.
package eth_pkg;

  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [15:0] ethertype;
  } eth_meta_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } filt_state_t;

  // Bit 40 is the I/G bit of the first octet on the wire.
  function automatic logic dst_accept(
    input logic [47:0] dst,
    input logic [47:0] local_mac,
    input logic        promisc,
    input logic        acc_bcast,
    input logic        acc_mcast
  );
    logic is_bcast;
    is_bcast = (dst == MAC_BCAST);
    return promisc | (dst == local_mac) | (is_bcast & acc_bcast) |
           (dst[40] & ~is_bcast & acc_mcast);
  endfunction

endpackage

// File: rtl/eth_rx_frame_filter_skid.sv
// Two-entry AXI-Stream register slice with a registered upstream ready.
// Generic payload width so it can be dropped into the TX path unchanged.
module axis_skid_buffer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] out_data_r, out_data_n;
  logic             out_valid_r, out_valid_n;
  logic [WIDTH-1:0] skid_data_r, skid_data_n;
  logic             skid_valid_r, skid_valid_n;
  logic             ready_r;
  logic             push_s;

  assign push_s  = s_valid & ready_r;
  assign s_ready = ready_r;
  assign m_data  = out_data_r;
  assign m_valid = out_valid_r;

  // Next-state: the skid entry is drained first so beat order is kept.
  always_comb begin
    out_data_n   = out_data_r;
    out_valid_n  = out_valid_r;
    skid_data_n  = skid_data_r;
    skid_valid_n = skid_valid_r;
    if (m_ready | ~out_valid_r) begin
      if (skid_valid_r) begin
        out_data_n   = skid_data_r;
        out_valid_n  = 1'b1;
        skid_valid_n = 1'b0;
      end else if (push_s) begin
        out_data_n  = s_data;
        out_valid_n = 1'b1;
      end else begin
        out_valid_n = 1'b0;
      end
    end else begin
      if (push_s) begin
        skid_data_n  = s_data;
        skid_valid_n = 1'b1;
      end else begin
        skid_valid_n = skid_valid_r;
      end
    end
  end

  // Slice registers; ready is precomputed from the next skid occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r   <= {WIDTH{1'b0}};
      out_valid_r  <= 1'b0;
      skid_data_r  <= {WIDTH{1'b0}};
      skid_valid_r <= 1'b0;
      ready_r      <= 1'b0;
    end else begin
      out_data_r   <= out_data_n;
      out_valid_r  <= out_valid_n;
      skid_data_r  <= skid_data_n;
      skid_valid_r <= skid_valid_n;
      ready_r      <= ~skid_valid_n;
    end
  end

endmodule

// File: rtl/eth_rx_frame_filter.sv
// Per-frame forward/discard decision on destination MAC and EtherType,
// registered output slice and saturating statistics.
module eth_rx_frame_filter
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  input  logic [47:0]           s_meta_dst_mac,
  input  logic [15:0]           s_meta_ethertype,
  input  logic                  s_meta_valid,
  input  logic [47:0]           cfg_local_mac,
  input  logic                  cfg_promisc,
  input  logic                  cfg_accept_bcast,
  input  logic                  cfg_accept_mcast,
  input  logic                  cfg_etype_en,
  input  logic [15:0]           cfg_etype0,
  input  logic [15:0]           cfg_etype1,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [CNT_WIDTH-1:0]  stat_pass_cnt,
  output logic [CNT_WIDTH-1:0]  stat_drop_cnt,
  output logic [CNT_WIDTH-1:0]  stat_meta_ovf
);

  localparam int PW = DATA_WIDTH + 2;

  generate
    if (DATA_WIDTH != 8) begin : g_width_check
      $error("eth_rx_frame_filter: only DATA_WIDTH=8 is supported");
    end
  endgenerate

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  filt_state_t   state_r, state_n;
  eth_meta_t     meta_r;
  logic          meta_pend_r;
  logic          consume_s, pass_s, etype_ok_s, in_hs_s;
  logic          skid_valid_s, skid_ready_s, skid_m_valid_s;
  logic [PW-1:0] skid_in_s, skid_out_s;

  assign consume_s  = (state_r == IDLE) & meta_pend_r;
  assign etype_ok_s = ~cfg_etype_en | (meta_r.ethertype == cfg_etype0) |
                      (meta_r.ethertype == cfg_etype1);
  assign pass_s     = dst_accept(meta_r.dst_mac, cfg_local_mac, cfg_promisc,
                                 cfg_accept_bcast, cfg_accept_mcast) & etype_ok_s;
  assign in_hs_s    = s_axis_tvalid & s_axis_tready;

  // Upstream ready depends only on registered state.
  always_comb begin
    s_axis_tready = 1'b0;
    skid_valid_s  = 1'b0;
    case (state_r)
      PASS: begin
        s_axis_tready = skid_ready_s;
        skid_valid_s  = s_axis_tvalid;
      end
      DROP:    s_axis_tready = 1'b1;
      IDLE:    s_axis_tready = 1'b0;
      default: s_axis_tready = 1'b0;
    endcase
  end

  // Next-state: cfg is only looked at in the single IDLE decision cycle.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (meta_pend_r) begin
          if (pass_s) state_n = PASS;
          else        state_n = DROP;
        end else begin
          state_n = IDLE;
        end
      end
      PASS: begin
        if (in_hs_s & s_axis_tlast) state_n = IDLE;
        else                        state_n = PASS;
      end
      DROP: begin
        if (in_hs_s & s_axis_tlast) state_n = IDLE;
        else                        state_n = DROP;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_n;
  end

  // One-entry metadata holding register; a pulse that finds it occupied is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r        <= '{dst_mac: 48'h0, ethertype: 16'h0};
      meta_pend_r   <= 1'b0;
      stat_meta_ovf <= {CNT_WIDTH{1'b0}};
    end else if (s_meta_valid) begin
      if (!meta_pend_r || consume_s) begin
        meta_r      <= '{dst_mac: s_meta_dst_mac, ethertype: s_meta_ethertype};
        meta_pend_r <= 1'b1;
      end else begin
        stat_meta_ovf <= sat_inc(stat_meta_ovf);
      end
    end else if (consume_s) begin
      meta_pend_r <= 1'b0;
    end
  end

  // Frame statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pass_cnt <= {CNT_WIDTH{1'b0}};
      stat_drop_cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
        stat_pass_cnt <= sat_inc(stat_pass_cnt);
      if ((state_r == DROP) && in_hs_s && s_axis_tlast)
        stat_drop_cnt <= sat_inc(stat_drop_cnt);
    end
  end

  assign skid_in_s = {s_axis_tuser, s_axis_tlast, s_axis_tdata};

  axis_skid_buffer #(.WIDTH(PW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (skid_in_s),
    .s_valid (skid_valid_s),
    .s_ready (skid_ready_s),
    .m_data  (skid_out_s),
    .m_valid (skid_m_valid_s),
    .m_ready (m_axis_tready)
  );

  assign m_axis_tvalid = skid_m_valid_s;
  assign m_axis_tdata  = skid_out_s[DATA_WIDTH-1:0];
  assign m_axis_tlast  = skid_out_s[DATA_WIDTH];
  assign m_axis_tuser  = skid_out_s[DATA_WIDTH+1];

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// Scoreboard bench for eth_rx_frame_filter: directed scenarios plus randomized
// frames checked against a rule-level model of the filter.
module tb_eth_rx_frame_filter;
  import eth_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic [47:0] s_meta_dst_mac;
  logic [15:0] s_meta_ethertype;
  logic        s_meta_valid;
  logic [47:0] cfg_local_mac;
  logic        cfg_promisc, cfg_accept_bcast, cfg_accept_mcast, cfg_etype_en;
  logic [15:0] cfg_etype0, cfg_etype1;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [31:0] stat_pass_cnt, stat_drop_cnt, stat_meta_ovf;

  eth_rx_frame_filter #(.DATA_WIDTH(8), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .s_meta_dst_mac(s_meta_dst_mac), .s_meta_ethertype(s_meta_ethertype), .s_meta_valid(s_meta_valid),
    .cfg_local_mac(cfg_local_mac), .cfg_promisc(cfg_promisc), .cfg_accept_bcast(cfg_accept_bcast),
    .cfg_accept_mcast(cfg_accept_mcast), .cfg_etype_en(cfg_etype_en),
    .cfg_etype0(cfg_etype0), .cfg_etype1(cfg_etype1),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .stat_pass_cnt(stat_pass_cnt), .stat_drop_cnt(stat_drop_cnt), .stat_meta_ovf(stat_meta_ovf)
  );

  always #4 clk = ~clk;

  localparam logic [47:0] LOCAL   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] FOREIGN = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST   = 48'hFF_FF_FF_FF_FF_FF;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] sb_q[$];
  int rdy_mode = 0;
  bit tog = 1'b1;
  int exp_pass = 0, exp_drop = 0, exp_ovf = 0;
  eth_meta_t slot;
  bit slot_full = 1'b0;
  bit cfg_chg = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // The filter rules as stated, evaluated on the frame's metadata.
  function automatic bit model_pass(input eth_meta_t m);
    logic [7:0] first_octet;
    bit is_bcast, is_group, dst_ok, etype_ok;
    first_octet = m.dst_mac[47:40];
    is_bcast = (m.dst_mac == BCAST);
    is_group = first_octet[0];
    dst_ok   = cfg_promisc || (m.dst_mac == cfg_local_mac) ||
               (is_bcast && cfg_accept_bcast) || (is_group && !is_bcast && cfg_accept_mcast);
    etype_ok = !cfg_etype_en || (m.ethertype == cfg_etype0) || (m.ethertype == cfg_etype1);
    return dst_ok && etype_ok;
  endfunction

  function automatic eth_meta_t rand_meta();
    eth_meta_t m;
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0:       m.dst_mac = LOCAL;
      1:       m.dst_mac = BCAST;
      2:       m.dst_mac = r[47:0] & ~48'h01_00_00_00_00_00;
      default: m.dst_mac = r[47:0] | 48'h01_00_00_00_00_00;
    endcase
    case ($urandom_range(0, 3))
      0:       m.ethertype = cfg_etype0;
      1:       m.ethertype = cfg_etype1;
      2:       m.ethertype = 16'h86DD;
      default: m.ethertype = r[63:48];
    endcase
    return m;
  endfunction

  task automatic rand_cfg();
    cfg_promisc      = ($urandom_range(0, 4) == 0);
    cfg_accept_bcast = 1'($urandom_range(0, 1));
    cfg_accept_mcast = 1'($urandom_range(0, 1));
    cfg_etype_en     = 1'($urandom_range(0, 1));
    cfg_etype0       = ($urandom_range(0, 1) == 1) ? 16'h0800 : 16'h86DD;
    cfg_etype1       = ($urandom_range(0, 1) == 1) ? 16'h0806 : 16'h88F7;
  endtask

  // Output side: drives m_axis_tready each negedge and checks the beat that
  // will transfer at the following posedge.
  initial begin
    logic [9:0] word, prev_word, exp_w;
    bit r, prev_stall;
    m_axis_tready = 1'b0;
    prev_stall = 1'b0;
    prev_word = 10'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        m_axis_tready = 1'b0;
      end else begin
        case (rdy_mode)
          0: r = 1'b1;
          1: begin r = tog; tog = !tog; end
          default: r = 1'($urandom_range(0, 1));
        endcase
        m_axis_tready = r;
        word = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        if (prev_stall) check("stall_hold", {53'h0, m_axis_tvalid, word}, {53'h0, 1'b1, prev_word});
        if (m_axis_tvalid && r) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h expected no output", word);
          end else begin
            exp_w = sb_q.pop_front();
            check("out_beat", {54'h0, word}, {54'h0, exp_w});
          end
        end
        prev_stall = m_axis_tvalid && !r;
        prev_word  = word;
      end
    end
  end

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic drive_beat(input logic [7:0] d, input logic last, input logic user,
                            input bit pulse, input eth_meta_t pm, input bit expect_ready);
    bit acc;
    int waits = 0;
    s_axis_tdata = d; s_axis_tlast = last; s_axis_tuser = user; s_axis_tvalid = 1'b1;
    if (pulse) begin
      s_meta_valid = 1'b1; s_meta_dst_mac = pm.dst_mac; s_meta_ethertype = pm.ethertype;
    end
    if (expect_ready) check("drop_ready", {63'h0, s_axis_tready}, 64'h1);
    forever begin
      acc = s_axis_tready;
      @(negedge clk);
      s_meta_valid = 1'b0;
      if (acc) break;
      waits++;
      if (waits > 1000) begin
        n_checks++; n_fail++;
        $display("FAIL beat_timeout: got no s_axis_tready in %0d cycles, expected acceptance", waits);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic pulse_meta(input eth_meta_t m);
    s_meta_valid = 1'b1; s_meta_dst_mac = m.dst_mac; s_meta_ethertype = m.ethertype;
    @(negedge clk);
    s_meta_valid = 1'b0;
  endtask

  task automatic send_frame(input eth_meta_t m, input int len, input logic user, input int n_extra,
                            input eth_meta_t x0, input eth_meta_t x1, input bit gaps);
    eth_meta_t fm, pm;
    bit pass, pulse;
    logic [7:0] d;
    logic last, u;
    if (!slot_full) begin
      pulse_meta(m);
      slot = m; slot_full = 1'b1;
    end
    fm = slot; slot_full = 1'b0;
    pass = model_pass(fm);
    if (pass) exp_pass++; else exp_drop++;
    for (int i = 0; i < len; i++) begin
      d = 8'($urandom());
      last = (i == len - 1);
      u = last ? user : 1'b0;
      if (pass) sb_q.push_back({u, last, d});
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      pulse = (i >= 1) && (i <= n_extra);
      pm = (i == 1) ? x0 : x1;
      if (pulse) begin
        if (slot_full) exp_ovf++;
        else begin slot = pm; slot_full = 1'b1; end
      end
      if (i == 1 && cfg_chg) begin rand_cfg(); cfg_chg = 1'b0; end
      drive_beat(d, last, u, pulse, pm, !pass && i > 0);
    end
  endtask

  task automatic drain_and_check(input string tag);
    int w = 0;
    while ((sb_q.size() != 0 || m_axis_tvalid) && w < 2000) begin
      @(negedge clk); w++;
    end
    if (w >= 2000) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout_%s: got %0d beats pending, expected 0", tag, sb_q.size());
    end
    repeat (2) @(negedge clk);
    check({"pass_cnt_", tag}, {32'h0, stat_pass_cnt}, 64'(exp_pass));
    check({"drop_cnt_", tag}, {32'h0, stat_drop_cnt}, 64'(exp_drop));
    check({"ovf_cnt_", tag},  {32'h0, stat_meta_ovf}, 64'(exp_ovf));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({"rst_s_tready_", tag}, {63'h0, s_axis_tready}, 64'h0);
    check({"rst_m_tvalid_", tag}, {63'h0, m_axis_tvalid}, 64'h0);
    check({"rst_m_out_", tag}, {54'h0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, 64'h0);
    check({"rst_cnts_", tag}, {stat_pass_cnt, stat_drop_cnt | stat_meta_ovf}, 64'h0);
  endtask

  initial begin
    eth_meta_t m0, m1, m2;
    rst_n = 1'b1;
    s_axis_tdata = 8'h0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    s_meta_dst_mac = 48'h0; s_meta_ethertype = 16'h0; s_meta_valid = 1'b0;
    cfg_local_mac = LOCAL; cfg_promisc = 1'b0; cfg_accept_bcast = 1'b0;
    cfg_accept_mcast = 1'b0; cfg_etype_en = 1'b0; cfg_etype0 = 16'h0800; cfg_etype1 = 16'h88F7;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("init");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Local unicast, 64 bytes, always ready.
    rdy_mode = 0;
    send_frame('{LOCAL, 16'h0800}, 64, 1'b0, 0, '{LOCAL, 16'h0800}, '{LOCAL, 16'h0800}, 1'b0);
    drain_and_check("local");

    // Foreign unicast is dropped.
    send_frame('{FOREIGN, 16'h0800}, 32, 1'b0, 0, '{LOCAL, 16'h0800}, '{LOCAL, 16'h0800}, 1'b0);
    drain_and_check("foreign");

    // Broadcast with EtherType filtering.
    cfg_accept_bcast = 1'b1; cfg_etype_en = 1'b1;
    send_frame('{BCAST, 16'h0800}, 20, 1'b0, 0, '{LOCAL, 16'h0800}, '{LOCAL, 16'h0800}, 1'b0);
    send_frame('{BCAST, 16'h86DD}, 20, 1'b1, 0, '{LOCAL, 16'h0800}, '{LOCAL, 16'h0800}, 1'b0);
    drain_and_check("bcast");

    // Alternating downstream ready.
    rdy_mode = 1;
    send_frame('{LOCAL, 16'h0800}, 16, 1'b1, 0, '{LOCAL, 16'h0800}, '{LOCAL, 16'h0800}, 1'b0);
    drain_and_check("bp");
    rdy_mode = 0;

    // Metadata overflow: second pulse held (foreign -> drop), third lost.
    send_frame('{LOCAL, 16'h0800}, 40, 1'b0, 2, '{FOREIGN, 16'h0800}, '{LOCAL, 16'h0806}, 1'b0);
    send_frame('{LOCAL, 16'h0800}, 10, 1'b0, 0, '{LOCAL, 16'h0800}, '{LOCAL, 16'h0800}, 1'b0);
    drain_and_check("ovf");

    // Randomized frames, configuration changes mid-frame.
    for (int f = 0; f < 40; f++) begin
      int len, nx;
      rdy_mode = $urandom_range(0, 2);
      len = $urandom_range(1, 20);
      nx = (len > 2) ? $urandom_range(0, 2) : 0;
      cfg_chg = ($urandom_range(0, 2) == 0);
      m0 = rand_meta(); m1 = rand_meta(); m2 = rand_meta();
      send_frame(m0, len, 1'($urandom_range(0, 1)), nx, m1, m2, 1'($urandom_range(0, 1)));
    end
    drain_and_check("rand");

    // Reset in the middle of a forwarded frame.
    rdy_mode = 0;
    cfg_promisc = 1'b1;
    if (slot_full) begin
      send_frame('{LOCAL, 16'h0800}, 2, 1'b0, 0, '{LOCAL, 16'h0800}, '{LOCAL, 16'h0800}, 1'b0);
    end
    m0 = '{FOREIGN, 16'h1234};
    pulse_meta(m0);
    for (int i = 0; i < 10; i++) begin
      m1 = '{48'h0, 16'h0};
      sb_q.push_back({1'b0, 1'b0, 8'(i + 8'h40)});
      drive_beat(8'(i + 8'h40), 1'b0, 1'b0, 1'b0, m1, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid");
    sb_q.delete();
    exp_pass = 0; exp_drop = 0; exp_ovf = 0; slot_full = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame('{LOCAL, 16'h0800}, 1, 1'b1, 0, '{LOCAL, 16'h0800}, '{LOCAL, 16'h0800}, 1'b0);
    drain_and_check("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame_filter.md
Name: eth_rx_frame_filter

Overview:
Sits directly downstream of the Ethernet frame parser in the RX path on the 125 MHz domain. Consumes the parser's 8-bit payload AXI-Stream and its per-frame header metadata. Decides per frame, from destination MAC and EtherType, whether to forward or silently discard the frame. Forwards accepted frames through a registered skid stage and keeps saturating statistics counters.

Parameters:
DATA_WIDTH, 8, stream byte width; only 8 is supported, any other value is an elaboration error
CNT_WIDTH, 32, width of each statistics counter

Ports:
clk  in  1  system clock (125 MHz)
rst_n  in  1  reset, asynchronous, active-low
s_axis_tdata  in  8  payload byte from parser
s_axis_tvalid  in  1  payload beat valid
s_axis_tready  out  1  payload beat ready
s_axis_tlast  in  1  last payload beat of frame
s_axis_tuser  in  1  frame error flag, meaningful on the tlast beat
s_meta_dst_mac  in  48  destination MAC; [47:40] is the first octet on the wire
s_meta_ethertype  in  16  EtherType/length field
s_meta_valid  in  1  one-cycle pulse per frame, no backpressure, arrives at or before the frame's first payload beat
cfg_local_mac  in  48  station MAC
cfg_promisc  in  1  accept all destinations
cfg_accept_bcast  in  1  accept FF:FF:FF:FF:FF:FF
cfg_accept_mcast  in  1  accept dst_mac[40]=1 (non-broadcast)
cfg_etype_en  in  1  enable EtherType filtering
cfg_etype0  in  16  permitted EtherType 0
cfg_etype1  in  16  permitted EtherType 1
m_axis_tdata  out  8  forwarded byte
m_axis_tvalid  out  1  forwarded beat valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last forwarded beat
m_axis_tuser  out  1  error flag copied from s_axis_tuser on the tlast beat
stat_pass_cnt  out  CNT_WIDTH  frames forwarded; increments on the tlast handshake
stat_drop_cnt  out  CNT_WIDTH  frames discarded; increments on the tlast accept while in DROP
stat_meta_ovf  out  CNT_WIDTH  metadata pulses lost to overflow

Behaviour:
- Reset, asynchronous: state=IDLE, meta_pend=0, skid empty.
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0.
  - All counters 0.
- Metadata capture:
  - A one-entry pending register latches the metadata on s_meta_valid and sets meta_pend.
  - If s_meta_valid fires while meta_pend=1 and the entry is not consumed that cycle, the new metadata is discarded and stat_meta_ovf increments.
  - If the entry is consumed in the same cycle, the new metadata replaces it.
- Decision, combinational from the pending entry:
  - dst_ok = cfg_promisc | (dst==cfg_local_mac) | (dst==BCAST & cfg_accept_bcast) | (dst[40] & dst!=BCAST & cfg_accept_mcast).
  - etype_ok = !cfg_etype_en | ethertype==cfg_etype0 | ethertype==cfg_etype1.
  - pass = dst_ok & etype_ok.
  - cfg_* are sampled only at the decision cycle; changes mid-frame do not affect the current frame.
- FSM:
  - IDLE: s_axis_tready=0. If meta_pend, consume the entry and go to PASS if pass, else DROP (one cycle).
  - PASS: s_axis_tready = skid ready. Beats are pushed to the skid. On an accepted tlast, go to IDLE.
  - DROP: s_axis_tready=1. Beats are discarded. On an accepted tlast, increment stat_drop_cnt and go to IDLE.
- Latency:
  - Metadata pulse to first input beat accepted: ≥1 cycle.
  - Input accept to m_axis_tvalid: 1 cycle.
  - Full throughput of 1 byte/cycle within a frame when m_axis_tready=1.
  - One idle input cycle between frames.
- Skid stage:
  - Two-entry register slice; s-side ready is registered.
  - m_axis_* are stable while tvalid=1 and tready=0.
- Counters:
  - Saturate at all-ones, no wrap.
  - stat_pass_cnt increments on the m_axis tlast handshake.
- Single-beat frame (tvalid & tlast on the first beat) is handled in both PASS and DROP.
- Reset mid-frame: output truncates immediately, with no tlast emitted. After reset the block waits in IDLE for new metadata; any payload remaining from the interrupted frame is held by backpressure until that metadata arrives.

Decomposition:
- Package eth_pkg:
  - typedef eth_meta_t (dst_mac[47:0], ethertype[15:0])
  - localparam MAC_BCAST = 48'hFFFF_FFFF_FFFF
  - enum filt_state_t {IDLE, PASS, DROP}
- Sub-module axis_skid_buffer (DATA_WIDTH+2 bits payload, covering data, last and user), reusable on the TX path.

Test Plan:
1. Local unicast: cfg_local_mac=02:00:00:00:00:01, meta dst equal, 64-byte frame, m_axis_tready=1 -> 64 identical bytes out, tlast on byte 64, stat_pass_cnt=1.
2. Foreign unicast dst=02:00:00:00:00:02, promisc=0 -> no m_axis_tvalid, s_axis_tready=1 throughout frame, stat_drop_cnt=1.
3. Broadcast with accept_bcast=1 and etype_en=1, etype0=0x0800, frames with EtherType 0x0800 then 0x86DD -> first forwarded, second dropped; pass=1, drop=1.
4. Backpressure: m_axis_tready toggling 1010… on a 16-byte passed frame -> output byte order preserved, no beat lost or duplicated, data stable while stalled.
5. Metadata overflow: three s_meta_valid pulses while a long frame is in PASS -> stat_meta_ovf=1; the second frame uses the second pulse's metadata.
6. rst_n asserted mid-frame at byte 10 -> outputs go to reset values asynchronously, counters 0; after release plus a new meta pulse and a 1-byte frame -> single beat out with tlast=1.
